// File: rtl/core_pkg.sv
// Shared constants, state encoding and IF/ID payload layout for the core pipeline.
package core_pkg;

  localparam int unsigned PC_W   = 12;
  localparam int unsigned CU_W   = 5;
  localparam int unsigned DP_W   = 14;
  localparam int unsigned INS_W  = 19;
  localparam int unsigned CU_MSB = 18;
  localparam int unsigned CU_LSB = 14;
  localparam int unsigned DRAIN  = 3;
  localparam int unsigned CNT_W  = $clog2(DRAIN + 1);

  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    RUN,
    HALT_PEND,
    HALTED
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [CU_W-1:0] cu;
    logic [DP_W-1:0] dp;
    logic [PC_W-1:0] pc1;
  } ifid_t;

  // A bubble is all-zero, so it aliases the halt encoding; consumers must qualify on valid.
  localparam ifid_t BUBBLE = '0;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise it holds.
module ifid_reg
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  logic  i_bubble,
  input  ifid_t i_data,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= BUBBLE;
    end else if (i_bubble) begin
      r_q <= BUBBLE;
    end else if (i_load) begin
      r_q <= i_data;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, halt drain FSM and the IF/ID register.
module fetch_stage
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc_o,
  input  logic [CU_W-1:0] imem_cu_i,
  input  logic [DP_W-1:0] imem_dp_i,
  input  logic            imem_halt_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic            ifid_valid_o,
  output logic [CU_W-1:0] ifid_cu_o,
  output logic [DP_W-1:0] ifid_dp_o,
  output logic [PC_W-1:0] ifid_pc1_o,
  output logic            halted_o
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_pc_inc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_halted;
  logic             w_load;
  logic             w_bubble;
  ifid_t            w_ifid_d;
  ifid_t            w_ifid_q;

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_ifid_d = '{valid: 1'b1, cu: imem_cu_i, dp: imem_dp_i, pc1: w_pc_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_pc     <= RESET_PC;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_halted <= r_halted | (r_state == HALTED);
    end
  end

  // Priority inside each state: redirect > stall > halt > normal fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      RUN: begin
        if (redirect_i) begin
          w_pc_nxt = redirect_pc_i;
          w_bubble = 1'b1;
        end else if (stall_i) begin
          w_bubble = 1'b0;
        end else if (imem_halt_i) begin
          w_bubble    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = HALT_PEND;
        end else begin
          w_load   = 1'b1;
          w_pc_nxt = w_pc_inc;
        end
      end
      HALT_PEND: begin
        // The halt may sit on a wrong path, so a late redirect still cancels it.
        if (redirect_i) begin
          w_pc_nxt    = redirect_pc_i;
          w_bubble    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
        end else if (!stall_i) begin
          w_bubble  = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DRAIN - 1)) begin
            w_state_nxt = HALTED;
          end
        end
      end
      HALTED: begin
        w_bubble = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_data   (w_ifid_d),
    .o_q      (w_ifid_q)
  );

  assign pc_o         = r_pc;
  assign ifid_valid_o = w_ifid_q.valid;
  assign ifid_cu_o    = w_ifid_q.cu;
  assign ifid_dp_o    = w_ifid_q.dp;
  assign ifid_pc1_o   = w_ifid_q.pc1;
  assign halted_o     = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed plan followed by random traffic against a cycle model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pc_o;
  logic [4:0]  imem_cu_i;
  logic [13:0] imem_dp_i;
  logic        imem_halt_i;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [11:0] redirect_pc_i = '0;
  logic        ifid_valid_o;
  logic [4:0]  ifid_cu_o;
  logic [13:0] ifid_dp_o;
  logic [11:0] ifid_pc1_o;
  logic        halted_o;

  logic [18:0] mem [4096];

  assign imem_cu_i   = mem[pc_o][18:14];
  assign imem_dp_i   = mem[pc_o][13:0];
  assign imem_halt_i = (mem[pc_o] == 19'd0);

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_o          (pc_o),
    .imem_cu_i     (imem_cu_i),
    .imem_dp_i     (imem_dp_i),
    .imem_halt_i   (imem_halt_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_cu_o     (ifid_cu_o),
    .ifid_dp_o     (ifid_dp_o),
    .ifid_pc1_o    (ifid_pc1_o),
    .halted_o      (halted_o)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: mode 0 = fetching, 1 = halt seen and draining, 2 = halted.
  localparam int DRAIN = 3;
  int          m_mode;
  int          m_drained;
  logic [11:0] m_pc;
  logic        m_valid;
  logic [4:0]  m_cu;
  logic [13:0] m_dp;
  logic [11:0] m_pc1;
  logic        m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic to_bubble();
    m_valid = 1'b0; m_cu = '0; m_dp = '0; m_pc1 = '0;
  endtask

  // One clock: drive inputs, advance the model by the stage rules, compare every output.
  task automatic cycle(input bit r, input bit st, input bit rd, input logic [11:0] rpc);
    logic [18:0] word;
    bit          was_halted;
    @(negedge clk);
    rst = r; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    word = mem[m_pc];
    was_halted = (m_mode == 2);
    if (r) begin
      m_pc = 12'd0; to_bubble(); m_mode = 0; m_drained = 0;
      m_halted = 1'b0;
    end else begin
      if (m_mode == 0) begin
        if (rd) begin
          m_pc = rpc; to_bubble();
        end else if (!st) begin
          if (word == 19'd0) begin
            to_bubble(); m_drained = 0; m_mode = 1;
          end else begin
            m_valid = 1'b1; m_cu = word[18:14]; m_dp = word[13:0];
            m_pc = m_pc + 12'd1; m_pc1 = m_pc;
          end
        end
      end else if (m_mode == 1) begin
        if (rd) begin
          m_pc = rpc; to_bubble(); m_drained = 0; m_mode = 0;
        end else if (!st) begin
          to_bubble();
          m_drained = m_drained + 1;
          if (m_drained == DRAIN) m_mode = 2;
        end
      end else begin
        to_bubble();
      end
      if (was_halted) m_halted = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("pc_o",   32'(pc_o),         32'(m_pc));
    chk("valid",  32'(ifid_valid_o), 32'(m_valid));
    chk("cu",     32'(ifid_cu_o),    32'(m_cu));
    chk("dp",     32'(ifid_dp_o),    32'(m_dp));
    chk("pc1",    32'(ifid_pc1_o),   32'(m_pc1));
    chk("halted", 32'(halted_o),     32'(m_halted));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 19'($urandom_range(1, 19'h7FFFF));
    end
    mem[0] = 19'h40864;
    mem[1] = 19'h41066;
    mem[2] = 19'h01940;
    m_mode = 0; m_drained = 0; m_pc = '0; m_halted = 1'b0; to_bubble();

    // Reset, then three free-running fetches with explicit plan values.
    cycle(1, 0, 0, '0);
    cycle(0, 0, 0, '0);
    chk("plan_cu0", 32'(ifid_cu_o), 32'h10);
    chk("plan_dp0", 32'(ifid_dp_o), 32'h0864);
    cycle(0, 0, 0, '0);
    chk("plan_dp1", 32'(ifid_dp_o), 32'h1066);
    cycle(0, 0, 0, '0);
    chk("plan_cu2", 32'(ifid_cu_o), 32'h00);
    chk("plan_pc3", 32'(pc_o), 32'd3);

    // Reach pc=5, stall two cycles, release.
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    cycle(0, 1, 0, '0);
    cycle(0, 1, 0, '0);
    chk("stall_pc", 32'(pc_o), 32'd5);
    cycle(0, 0, 0, '0);
    chk("resume_pc", 32'(pc_o), 32'd6);

    // Redirect together with stall: redirect wins.
    cycle(0, 1, 1, 12'h0A0);
    chk("redir_pc", 32'(pc_o), 32'h0A0);

    // Halt at pc=8 drains, then halts; a later redirect is ignored.
    mem[8] = 19'd0;
    cycle(0, 0, 1, 12'd8);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    chk("halt_early", 32'(halted_o), 32'd0);
    cycle(0, 0, 0, '0);
    chk("halt_at4", 32'(halted_o), 32'd1);
    cycle(0, 0, 1, 12'h123);
    chk("halted_pc", 32'(pc_o), 32'd8);

    // Reset out of HALTED, then a halt cancelled by a redirect one cycle later.
    cycle(1, 0, 0, '0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    cycle(0, 0, 1, 12'd8);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 1, 12'h020);
    chk("cancel_pc", 32'(pc_o), 32'h020);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, '0);
    chk("cancel_halted", 32'(halted_o), 32'd0);

    // PC wrap from 4095 to 0.
    cycle(0, 0, 1, 12'hFFF);
    cycle(0, 0, 0, '0);
    chk("wrap_pc", 32'(pc_o), 32'd0);
    chk("wrap_pc1", 32'(ifid_pc1_o), 32'd0);

    // Random traffic with sparse halt words and occasional resets.
    for (int i = 0; i < 40; i++) mem[$urandom_range(0, 4095)] = 19'd0;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 10), 12'($urandom_range(0, 4095)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage pipelined core: owns the 12-bit PC and drives it to the combinational instruction memory.
- Registers the returned 19-bit instruction, split as 5-bit CU field and 14-bit datapath field, into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, and all-zero halt drain sequencing.

Parameters:
- PC_W, 12, PC / instruction-address width
- CU_W, 5, control-unit opcode field width (instruction bits 18:14)
- DP_W, 14, datapath field width (instruction bits 13:0)
- RESET_PC, 0, PC value after reset
- DRAIN, 3, cycles an older instruction needs to retire after a halt is fetched (ID..WB depth minus 1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- pc_o  out  PC_W  fetch address to instruction memory
- imem_cu_i  in  CU_W  CU field returned for pc_o (same cycle, combinational)
- imem_dp_i  in  DP_W  datapath field returned for pc_o
- imem_halt_i  in  1  instruction at pc_o is all-zero
- stall_i  in  1  hazard unit: hold PC and IF/ID
- redirect_i  in  1  taken branch/jump resolved downstream
- redirect_pc_i  in  PC_W  redirect target
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_cu_o  out  CU_W  registered CU field
- ifid_dp_o  out  DP_W  registered datapath field
- ifid_pc1_o  out  PC_W  registered PC+1 of that instruction
- halted_o  out  1  core has halted (sticky)

Behaviour:
- Reset values:
  - pc_o = RESET_PC
  - ifid_valid_o = 0; ifid_cu_o, ifid_dp_o, ifid_pc1_o = 0
  - halted_o = 0
  - state = RUN; drain counter = 0
  - Reset mid-operation (any state) restores all of the above on the next edge.
- Bubble: valid=0 with all payload fields 0. Downstream must qualify on valid, because a bubble payload equals the halt encoding.
- States: RUN, HALT_PEND, HALTED. Per-edge priority: rst > redirect_i > stall_i > halt > normal.
- RUN:
  - redirect_i: PC <= redirect_pc_i; IF/ID <= bubble. Redirect beats a simultaneous stall_i.
  - stall_i (no redirect): PC and IF/ID hold all values.
  - imem_halt_i: PC holds; IF/ID <= bubble; drain counter <= 0; go to HALT_PEND.
  - otherwise: IF/ID <= {valid=1, cu, dp, pc+1}; PC <= PC+1 mod 2^PC_W (4095 -> 0, no flag).
- HALT_PEND (the halt may lie on a wrong path):
  - redirect_i: PC <= redirect_pc_i; IF/ID <= bubble; counter cleared; back to RUN.
  - stall_i: PC, IF/ID and counter hold.
  - otherwise: IF/ID <= bubble; counter +1. When counter == DRAIN-1 at the edge, go to HALTED.
- HALTED:
  - halted_o = 1 (registered, asserted the cycle after entry).
  - PC frozen; IF/ID bubble.
  - redirect_i and stall_i ignored; only rst leaves this state.
- Latency:
  - Instruction at pc_o appears on the IF/ID outputs one cycle later.
  - Redirect target drives pc_o one cycle after redirect_i is sampled.
- Simultaneous imem_halt_i and redirect_i in RUN: redirect wins, halt discarded.

Decomposition:
- Shared package (core_pkg):
  - PC_W, CU_W, DP_W, INS_W=19
  - field slice positions CU_MSB=18, CU_LSB=14
  - state enum {RUN, HALT_PEND, HALTED}
  - BUBBLE constant
- One natural sub-module: ifid_reg, the IF/ID register with load/hold/bubble control.
- PC register, next-PC mux and FSM stay in fetch_stage.

Test Plan:
- Reset, then 3 free-running cycles with memory words 0x40864, 0x41066, 0x01940 -> pc_o 0,1,2,3; IF/ID shows cu=0x10,dp=0x0864,pc1=1, then cu=0x10,dp=0x1066,pc1=2, then cu=0x00,dp=0x1940,pc1=3; valid=1 throughout.
- stall_i high for 2 cycles at pc=5 -> pc_o stays 5 and IF/ID unchanged; resumes with pc_o=6 after release.
- redirect_i=1, redirect_pc_i=0x0A0, asserted together with stall_i -> next cycle pc_o=0x0A0 and ifid_valid_o=0.
- All-zero word at pc=8, no redirect -> pc_o held at 8; ifid_valid_o=0; halted_o rises exactly DRAIN+1=4 cycles after the halt fetch; a later redirect leaves pc_o at 8.
- Halt fetched at pc=8, redirect to 0x020 one cycle later -> state returns to RUN, pc_o=0x020, halted_o stays 0.
- PC preset to 4095 (non-halt word), one cycle -> pc_o=0, ifid_pc1_o=0; rst asserted in HALTED -> pc_o=0, halted_o=0 next cycle.
